// File: rtl/imem_loader_if.sv
// Host byte-stream link plus instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  start;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [INST_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  done;
    logic                  error;

    // Host side: drives the request and the byte stream, observes everything else.
    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error
    );

    // Loader side.
    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a 16-bit little-endian word count
// followed by little-endian instruction words over a byte stream and writes
// them to consecutive word addresses from 0, stalling the core while busy.
module imem_loader #(
    parameter int INST_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMEMORY_SIZE = 1024
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam int LANES  = INST_WIDTH / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t                state;
    logic [LANE_W-1:0]     byte_cnt;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [15:0]           length;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [INST_WIDTH-1:0] data_q;
    logic                  done_q;
    logic                  error_q;

    logic                  ready;
    logic                  xfer;
    logic                  last_lane;
    logic [15:0]           new_length;
    logic [ADDR_WIDTH:0]   word_next;

    assign ready      = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign xfer       = bus.byte_valid && ready;
    assign last_lane  = (32'(byte_cnt) == LANES - 1);
    assign new_length = {bus.byte_data, length[7:0]};
    assign word_next  = word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

    assign bus.byte_ready = ready;
    assign bus.busy       = ready || (state == WRITE);
    assign bus.wr_en      = (state == WRITE);
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = data_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

    // Load sequencer: header parse, byte-lane assembly and one write per word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            word_cnt <= '0;
            length   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state    <= LEN_LO;
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        length[7:0] <= bus.byte_data;
                        state       <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        length[15:8] <= bus.byte_data;
                        if (new_length == 16'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (32'(new_length) > 32'(IMEMORY_SIZE)) begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        data_q[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
                        if (last_lane) begin
                            byte_cnt <= '0;
                            addr_q   <= word_cnt[ADDR_WIDTH-1:0];
                            state    <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + LANE_W'(1);
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_next;
                    if (32'(word_next) == 32'(length)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes come from decoding
// each byte image into words; a monitor checks every write strobe.
module tb_imem_loader;
    localparam int INST_WIDTH   = 32;
    localparam int ADDR_WIDTH   = 16;
    localparam int IMEMORY_SIZE = 1024;

    logic clk;
    logic reset;

    imem_loader_if #(.INST_WIDTH(INST_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    imem_loader #(
        .INST_WIDTH(INST_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .IMEMORY_SIZE(IMEMORY_SIZE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [ADDR_WIDTH-1:0] exp_addr_q[$];
    logic [INST_WIDTH-1:0] exp_data_q[$];

    int wr_count = 0;
    logic [ADDR_WIDTH-1:0] wlog_addr[0:IMEMORY_SIZE-1];
    logic [INST_WIDTH-1:0] wlog_data[0:IMEMORY_SIZE-1];
    int cyc = 0;
    int last_wr_cyc = 0;
    int done_rise_cyc = 0;
    logic prev_done = 1'b0;

    logic [7:0] img[$];

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Decode an image (16-bit LE word count, then LE words) into expected writes.
    task automatic expectImage(input logic [7:0] im[$]);
        int len;
        len = {im[1], im[0]};
        if (len == 0 || len > IMEMORY_SIZE) return;
        for (int w = 0; w < len; w++) begin
            exp_addr_q.push_back(ADDR_WIDTH'(w));
            exp_data_q.push_back({im[2+4*w+3], im[2+4*w+2], im[2+4*w+1], im[2+4*w]});
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int guard;
        logic rdy;
        guard = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        forever begin
            @(negedge clk);
            rdy = bus.byte_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL byte_accept_timeout: got no byte_ready in 100 cycles, expected acceptance");
                break;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] im[$], input bit gaps);
        foreach (im[i]) begin
            sendByte(im[i]);
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic doStart();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic waitIdle(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_idle_timeout: got busy after 300 cycles, expected idle", name);
        end
    endtask

    task automatic checkEnd(input string name, input logic exp_done, input logic exp_error, input int exp_writes);
        checkOutput({name, "_done"}, 32'(bus.done), 32'(exp_done));
        checkOutput({name, "_error"}, 32'(bus.error), 32'(exp_error));
        checkOutput({name, "_writes"}, 32'(wr_count), 32'(exp_writes));
        checkOutput({name, "_pending"}, 32'(exp_data_q.size()), 32'd0);
    endtask

    // Write monitor: every strobe must match the next expected write.
    initial begin
        logic [ADDR_WIDTH-1:0] ea;
        logic [INST_WIDTH-1:0] ed;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset && bus.wr_en) begin
                if (wr_count < IMEMORY_SIZE) begin
                    wlog_addr[wr_count] = bus.wr_addr;
                    wlog_data[wr_count] = bus.wr_data;
                end
                wr_count++;
                last_wr_cyc = cyc;
                checkOutput("busy_in_write", 32'(bus.busy), 32'd1);
                checkOutput("ready_in_write", 32'(bus.byte_ready), 32'd0);
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    checkOutput("write_addr", 32'(bus.wr_addr), 32'(ea));
                    checkOutput("write_data", 32'(bus.wr_data), 32'(ed));
                end
            end
            if (bus.done && !prev_done) done_rise_cyc = cyc;
            prev_done = bus.done;
        end
    end

    // Directed scenarios.
    initial begin
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("reset_wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_error", 32'(bus.error), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic two-word load, continuous stream.
        $display("[TB] basic load");
        wr_count = 0;
        img = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        expectImage(img);
        doStart();
        applyStimulus(img, 1'b0);
        waitIdle("basic");
        checkEnd("basic", 1'b1, 1'b0, 2);
        checkOutput("basic_addr0", 32'(wlog_addr[0]), 32'h0);
        checkOutput("basic_data0", wlog_data[0], 32'h12345678);
        checkOutput("basic_addr1", 32'(wlog_addr[1]), 32'h1);
        checkOutput("basic_data1", wlog_data[1], 32'hDEADBEEF);
        checkOutput("basic_done_latency", 32'(done_rise_cyc - last_wr_cyc), 32'd1);

        // Same image with gaps between bytes.
        $display("[TB] gapped load");
        wr_count = 0;
        expectImage(img);
        doStart();
        checkOutput("gaps_done_cleared", 32'(bus.done), 32'd0);
        applyStimulus(img, 1'b1);
        waitIdle("gaps");
        checkEnd("gaps", 1'b1, 1'b0, 2);
        checkOutput("gaps_data1", wlog_data[1], 32'hDEADBEEF);

        // Zero length.
        $display("[TB] zero length");
        wr_count = 0;
        img = {8'h00, 8'h00};
        doStart();
        applyStimulus(img, 1'b0);
        waitIdle("zero");
        checkEnd("zero", 1'b1, 1'b0, 0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("zero_not_ready", 32'(bus.byte_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;

        // Oversize length, then a one-word load.
        $display("[TB] oversize");
        wr_count = 0;
        img = {8'h01, 8'h04};
        doStart();
        applyStimulus(img, 1'b0);
        waitIdle("over");
        checkEnd("over", 1'b0, 1'b1, 0);
        img = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        expectImage(img);
        doStart();
        checkOutput("over_error_cleared", 32'(bus.error), 32'd0);
        applyStimulus(img, 1'b0);
        waitIdle("one");
        checkEnd("one", 1'b1, 1'b0, 1);
        checkOutput("one_data0", wlog_data[0], 32'hDDCCBBAA);

        // Reset in the middle of the second word.
        $display("[TB] reset mid-load");
        wr_count = 0;
        img = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_addr_q.push_back(16'h0);
        exp_data_q.push_back(32'h44332211);
        doStart();
        applyStimulus(img, 1'b0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h66;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.byte_valid = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        checkOutput("midreset_writes", 32'(wr_count), 32'd1);
        @(negedge clk);
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.byte_valid = 1'($urandom_range(0, 1));
            bus.byte_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
            checkOutput("midreset_no_wr", 32'(bus.wr_en), 32'd0);
            checkOutput("midreset_no_ready", 32'(bus.byte_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;

        // Full memory, word i = i, with a stray start mid-load.
        $display("[TB] full memory");
        wr_count = 0;
        img = {8'h00, 8'h04};
        for (int i = 0; i < IMEMORY_SIZE; i++) begin
            img.push_back(8'(i));
            img.push_back(8'(i >> 8));
            img.push_back(8'h00);
            img.push_back(8'h00);
        end
        expectImage(img);
        doStart();
        fork
            applyStimulus(img, 1'b0);
            begin
                repeat (2000) @(posedge clk);
                #1;
                bus.start = 1'b1;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end
        join
        waitIdle("full");
        checkEnd("full", 1'b1, 1'b0, IMEMORY_SIZE);
        checkOutput("full_last_addr", 32'(wlog_addr[IMEMORY_SIZE-1]), 32'd1023);
        checkOutput("full_last_data", wlog_data[IMEMORY_SIZE-1], 32'h3FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Streaming writer for the instruction memory: receives a program image as a byte stream from a host-side link, assembles bytes into instruction words, and issues one-word write strobes to the instruction memory's write port at consecutive word addresses starting at 0. While loading it holds the core stalled via `busy`. It is the write-side counterpart of the fetch path, which reads the same memory combinationally by `pc`.

## Interface
- `INST_WIDTH`, 32, instruction word width in bits; multiple of 8.
- `ADDR_WIDTH`, 16, word-address width; same indexing as `pc`.
- `IMEMORY_SIZE`, 1024, memory depth in words; ≤ 2^ADDR_WIDTH.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- `byte_valid`  in  1  host byte present.
- `byte_data`  in  8  host byte.
- `byte_ready`  out  1  loader accepts a byte this cycle (transfer = `byte_valid && byte_ready`).
- `wr_en`  out  1  one-cycle write strobe to instruction memory.
- `wr_addr`  out  ADDR_WIDTH  word address for `wr_en`.
- `wr_data`  out  INST_WIDTH  word for `wr_en`.
- `busy`  out  1  load in progress; core held stalled.
- `done`  out  1  level; last load completed successfully.
- `error`  out  1  level; last load rejected (length > IMEMORY_SIZE).

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
- Reset values: state IDLE; `byte_ready`, `wr_en`, `busy`, `done`, `error` = 0; `wr_addr`, `wr_data`, byte counter, word counter, length = 0. Memory contents not touched.
- IDLE/DONE/ERROR + `start` → LEN_LO; clears `done`, `error`, word counter, byte counter.
- LEN_LO: transfer stores length[7:0] → LEN_HI. LEN_HI: transfer stores length[15:8], then:
  - length == 0 → DONE.
  - length > IMEMORY_SIZE → ERROR (no writes issued).
  - else → DATA.
- DATA: each transfer places byte into word at lane = byte counter (little-endian: first byte → bits [7:0]). Byte counter wraps at INST_WIDTH/8; on the last byte of a word → WRITE.
- WRITE: `wr_en`=1 for exactly one cycle with `wr_addr` = word counter, `wr_data` = assembled word; word counter increments. If incremented count == length → DONE, else → DATA.
- Word counter and `wr_addr` never exceed length−1; no address wrap possible because length ≤ IMEMORY_SIZE.
- `start` while busy: ignored. `byte_valid` while `byte_ready`=0: byte not consumed; host holds it.
- Reset mid-load: immediate return to IDLE; partially written memory left as is; partial word discarded.

## Timing
- `byte_ready` = 1 exactly in LEN_LO, LEN_HI, DATA (registered state decode, combinational from state).
- `busy` = 1 in LEN_LO, LEN_HI, DATA, WRITE.
- Write latency: `wr_en` asserted the cycle after the transfer of a word's last byte; `byte_ready`=0 during that cycle (one bubble per word).
- Throughput: one word per INST_WIDTH/8 + 1 cycles with continuous `byte_valid`.
- `done`/`error` rise the cycle after the final WRITE (or LEN_HI transfer for zero/oversize length) and hold until next `start` or `reset`.
- `wr_addr`/`wr_data` stable while `wr_en`=1; don't-care otherwise.

## Test plan
- Reset: assert `reset` 2 cycles mid-stream → all outputs 0, state IDLE, no `wr_en` for the following 10 cycles of random `byte_valid`.
- Basic load: `start`, bytes 02 00, 78 56 34 12, EF BE AD DE continuous → `wr_en` pulses with (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF); `done`=1 cycle after second write; `busy` high from cycle after `start` through second WRITE.
- Backpressure/gaps: same image with `byte_valid` toggled every other cycle and held during WRITE bubble → identical writes, no byte lost or duplicated.
- Zero length: `start`, bytes 00 00 → no `wr_en`, `done`=1; subsequent bytes not accepted (`byte_ready`=0).
- Oversize: `start`, length 0x0401 (1025) with IMEMORY_SIZE=1024 → ERROR, `error`=1, `done`=0, no writes; new `start` with length 1 loads word to addr 0 and clears `error`.
- Full memory: length 1024, word i = i → 1024 writes, last at addr 1023 data 0x3FF, then `done`; `start` pulsed mid-load ignored.
